// File: rtl/jtag_tap_bsr_if.sv
// Scan-port interface: TMS/TDI driven by the test host, TDO/TDO_EN returned by the TAP.
interface jtag_tap_bsr_if;
    logic TMS;
    logic TDI;
    logic TDO;
    logic TDO_EN;

    modport master (
        output TMS,
        output TDI,
        input  TDO,
        input  TDO_EN
    );

    modport slave (
        input  TMS,
        input  TDI,
        output TDO,
        output TDO_EN
    );
endinterface

// File: rtl/jtag_tap_bsr.sv
// IEEE 1149.1-style TAP controller with a parametrised boundary-scan register,
// instruction register, bypass and IDCODE. Sits between pads and core logic.
module jtag_tap_bsr #(
    parameter int          N_IN   = 34,
    parameter int          N_OUT  = 17,
    parameter int          IR_W   = 4,
    parameter logic [31:0] IDCODE = 32'h1234_5A5B
) (
    input  logic              TCK,
    input  logic              RST,
    jtag_tap_bsr_if.slave     jtag,
    input  logic [N_IN-1:0]   sys_pin_in,
    output logic [N_IN-1:0]   core_pin_out,
    input  logic [N_OUT-1:0]  core_pin_in,
    output logic [N_OUT-1:0]  sys_pin_out
);

    localparam int BSR_W = N_IN + N_OUT;

    localparam logic [IR_W-1:0] OP_EXTEST  = IR_W'(0);
    localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1);
    localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(2);
    localparam logic [IR_W-1:0] OP_INTEST  = IR_W'(3);

    typedef enum logic [3:0] {
        S_TLR, S_RTI,
        S_SEL_DR, S_CAP_DR, S_SH_DR, S_EX1_DR, S_PAU_DR, S_EX2_DR, S_UPD_DR,
        S_SEL_IR, S_CAP_IR, S_SH_IR, S_EX1_IR, S_PAU_IR, S_EX2_IR, S_UPD_IR
    } tap_state_e;

    tap_state_e        state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
    logic [BSR_W-1:0]  bsr_q, bsr_d;
    logic [BSR_W-1:0]  upd_q, upd_d;
    logic [31:0]       id_q, id_d;
    logic              byp_q, byp_d;

    logic is_extest, is_intest, sel_bsr, sel_id, sel_byp;

    // Instruction decode; any opcode not listed selects bypass.
    always_comb begin
        is_extest = (ir_q == OP_EXTEST);
        is_intest = (ir_q == OP_INTEST);
        sel_bsr   = is_extest || is_intest || (ir_q == OP_SAMPLE);
        sel_id    = (ir_q == OP_IDCODE);
        sel_byp   = !sel_bsr && !sel_id;
    end

    // TAP state register.
    always_ff @(posedge TCK) begin
        if (RST) state_q <= S_TLR;
        else     state_q <= state_d;
    end

    // Standard TAP state transitions on TMS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_TLR:    state_d = jtag.TMS ? S_TLR    : S_RTI;
            S_RTI:    state_d = jtag.TMS ? S_SEL_DR : S_RTI;
            S_SEL_DR: state_d = jtag.TMS ? S_SEL_IR : S_CAP_DR;
            S_CAP_DR: state_d = jtag.TMS ? S_EX1_DR : S_SH_DR;
            S_SH_DR:  state_d = jtag.TMS ? S_EX1_DR : S_SH_DR;
            S_EX1_DR: state_d = jtag.TMS ? S_UPD_DR : S_PAU_DR;
            S_PAU_DR: state_d = jtag.TMS ? S_EX2_DR : S_PAU_DR;
            S_EX2_DR: state_d = jtag.TMS ? S_UPD_DR : S_SH_DR;
            S_UPD_DR: state_d = jtag.TMS ? S_SEL_DR : S_RTI;
            S_SEL_IR: state_d = jtag.TMS ? S_TLR    : S_CAP_IR;
            S_CAP_IR: state_d = jtag.TMS ? S_EX1_IR : S_SH_IR;
            S_SH_IR:  state_d = jtag.TMS ? S_EX1_IR : S_SH_IR;
            S_EX1_IR: state_d = jtag.TMS ? S_UPD_IR : S_PAU_IR;
            S_PAU_IR: state_d = jtag.TMS ? S_EX2_IR : S_PAU_IR;
            S_EX2_IR: state_d = jtag.TMS ? S_UPD_IR : S_SH_IR;
            S_UPD_IR: state_d = jtag.TMS ? S_SEL_DR : S_RTI;
            default:  state_d = S_TLR;
        endcase
    end

    // Capture/shift/update actions for IR and the selected data register.
    always_comb begin
        ir_d    = ir_q;
        ir_sr_d = ir_sr_q;
        bsr_d   = bsr_q;
        upd_d   = upd_q;
        id_d    = id_q;
        byp_d   = byp_q;
        case (state_q)
            S_TLR:    ir_d    = OP_IDCODE;
            S_CAP_IR: ir_sr_d = IR_W'(1);
            S_SH_IR:  ir_sr_d = {jtag.TDI, ir_sr_q[IR_W-1:1]};
            S_UPD_IR: ir_d    = ir_sr_q;
            S_CAP_DR: begin
                if (sel_bsr) bsr_d = {core_pin_in, sys_pin_in};
                if (sel_id)  id_d  = IDCODE;
                if (sel_byp) byp_d = 1'b0;
            end
            S_SH_DR: begin
                if (sel_bsr) bsr_d = {jtag.TDI, bsr_q[BSR_W-1:1]};
                if (sel_id)  id_d  = {jtag.TDI, id_q[31:1]};
                if (sel_byp) byp_d = jtag.TDI;
            end
            S_UPD_DR: if (sel_bsr) upd_d = bsr_q;
            default: ;
        endcase
    end

    // Register bank; reset discards shift contents and clears update latches.
    always_ff @(posedge TCK) begin
        if (RST) begin
            ir_q    <= OP_IDCODE;
            ir_sr_q <= '0;
            bsr_q   <= '0;
            upd_q   <= '0;
            id_q    <= '0;
            byp_q   <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            ir_sr_q <= ir_sr_d;
            bsr_q   <= bsr_d;
            upd_q   <= upd_d;
            id_q    <= id_d;
            byp_q   <= byp_d;
        end
    end

    // TDO mux: bit 0 of the register being shifted, quiet otherwise.
    always_comb begin
        jtag.TDO    = 1'b0;
        jtag.TDO_EN = 1'b0;
        if (state_q == S_SH_IR) begin
            jtag.TDO    = ir_sr_q[0];
            jtag.TDO_EN = 1'b1;
        end else if (state_q == S_SH_DR) begin
            jtag.TDO_EN = 1'b1;
            if (sel_bsr)     jtag.TDO = bsr_q[0];
            else if (sel_id) jtag.TDO = id_q[0];
            else             jtag.TDO = byp_q;
        end
    end

    // Pin muxing between pads, core and the boundary-scan update latches.
    always_comb begin
        core_pin_out = sys_pin_in;
        sys_pin_out  = core_pin_in;
        if (is_extest) begin
            sys_pin_out  = upd_q[BSR_W-1:N_IN];
        end else if (is_intest) begin
            core_pin_out = upd_q[N_IN-1:0];
            sys_pin_out  = upd_q[BSR_W-1:N_IN];
        end
    end

endmodule
